sudoku_check_seq: RTL

Sequencer that validates the 9x9 Sudoku board when the main FSM enters CHECKING. It scans all 27 groups (9 rows, 9 cols, 9 boxes) through a 1-cycle-latency board read port. It returns done plus solved, which feed the FSM's solved input. It sits between the main FSM (check_flag) and the board storage in the datapath.

---
 rtl/sudoku_pkg.sv | 34 +++
 rtl/sudoku_check_seq_if.sv | 24 ++
 rtl/sudoku_addr_gen.sv | 39 +++
 rtl/sudoku_check_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants, group-kind and sequencer state types for the Sudoku board checker.
package sudoku_pkg;

  localparam int unsigned CELL_W  = 4;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned GRID    = 9;
  localparam int unsigned NCELLS  = 81;
  localparam int unsigned NGROUPS = 27;
  localparam int unsigned GRP_W   = 5;
  localparam int unsigned IDX_W   = 4;

  localparam logic [GRP_W-1:0] ERR_NONE = GRP_W'(31);

  typedef enum logic [1:0] {
    GK_ROW,
    GK_COL,
    GK_BOX
  } group_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_REPORT
  } state_e;

  // Groups 0-8 are rows, 9-17 columns, 18-26 boxes.
  function automatic group_kind_e group_kind(input logic [GRP_W-1:0] g);
    if (g < GRP_W'(GRID))   return GK_ROW;
    if (g < GRP_W'(2*GRID)) return GK_COL;
    return GK_BOX;
  endfunction

endpackage

// File: rtl/sudoku_check_seq_if.sv
// Start/result handshake and board read port of the Sudoku checker.
interface sudoku_check_seq_if;
  import sudoku_pkg::*;

  logic                    check_start;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [CELL_W-1:0]       rd_data;
  logic                    busy;
  logic                    done;
  logic                    solved;
  logic [GRP_W-1:0]        err_group;

  modport master (
    output check_start, rd_data,
    input  rd_en, rd_addr, busy, done, solved, err_group
  );

  modport slave (
    input  check_start, rd_data,
    output rd_en, rd_addr, busy, done, solved, err_group
  );

endinterface

// File: rtl/sudoku_addr_gen.sv
// Maps (group, index) to the board cell address 9*row + col for rows, columns and 3x3 boxes.
module sudoku_addr_gen
  import sudoku_pkg::*;
(
  input  logic [GRP_W-1:0]  g,
  input  logic [IDX_W-1:0]  i,
  output logic [ADDR_W-1:0] addr_c
);

  logic [GRP_W-1:0] b;
  logic [IDX_W-1:0] r;
  logic [IDX_W-1:0] c;

  always_comb begin
    b = g - GRP_W'(2*GRID);
    r = '0;
    c = '0;
    case (group_kind(g))
      GK_ROW: begin
        r = IDX_W'(g);
        c = i;
      end
      GK_COL: begin
        r = i;
        c = IDX_W'(g - GRP_W'(GRID));
      end
      GK_BOX: begin
        r = IDX_W'(3 * (b / 3) + i / 3);
        c = IDX_W'(3 * (b % 3) + i % 3);
      end
      default: begin
        r = '0;
        c = '0;
      end
    endcase
    addr_c = ADDR_W'(GRID * r + c);
  end

endmodule

// File: rtl/sudoku_check_seq.sv
// Scans all 27 Sudoku groups through a 1-cycle-latency read port and reports solved/err_group.
// Optional macro EARLY_EXIT_EN: stop scanning and report on the first detected error.
module sudoku_check_seq
  import sudoku_pkg::*;
(
  input  logic              clka,
  input  logic              restart_n,
  sudoku_check_seq_if.slave bus
);

  state_e            state, state_nx;
  logic [GRP_W-1:0]  g, g_nx, g_d;
  logic [IDX_W-1:0]  i, i_nx;
  logic              grp_end_d;
  logic              vld_d;
  logic [GRID-1:0]   mask, mask_nx, onehot_c;
  logic              err, err_nx;
  logic              bad_c;
  logic [GRP_W-1:0]  err_group_nx;
  logic              solved_nx;
  logic [ADDR_W-1:0] addr_c;

  sudoku_addr_gen u_addr_gen (
    .g      (g_nx),
    .i      (i_nx),
    .addr_c (addr_c)
  );

  // Returned digit decode: out-of-range values and repeats within the group are errors.
  always_comb begin
    onehot_c = '0;
    if (bus.rd_data >= CELL_W'(1) && bus.rd_data <= CELL_W'(GRID))
      onehot_c = GRID'(1) << (bus.rd_data - CELL_W'(1));
    bad_c = (onehot_c == '0) || ((mask & onehot_c) != '0);
  end

  always_comb begin
    state_nx     = state;
    g_nx         = g;
    i_nx         = i;
    mask_nx      = mask;
    err_nx       = err;
    err_group_nx = bus.err_group;
    solved_nx    = bus.solved;

    case (state)
      ST_IDLE: begin
        if (bus.check_start) begin
          state_nx     = ST_SCAN;
          g_nx         = '0;
          i_nx         = '0;
          mask_nx      = '0;
          err_nx       = 1'b0;
          err_group_nx = ERR_NONE;
          solved_nx    = 1'b0;
        end
      end
      ST_SCAN: begin
        if (g == GRP_W'(NGROUPS-1) && i == IDX_W'(GRID-1)) begin
          state_nx = ST_DRAIN;
        end else if (i == IDX_W'(GRID-1)) begin
          i_nx = '0;
          g_nx = g + GRP_W'(1);
        end else begin
          i_nx = i + IDX_W'(1);
        end
      end
      ST_DRAIN:  state_nx = ST_REPORT;
      ST_REPORT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase

    // Data side runs one cycle behind the address; only the first error is captured.
    if ((state == ST_SCAN || state == ST_DRAIN) && vld_d) begin
      if (bad_c) begin
        if (!err) begin
          err_nx       = 1'b1;
          err_group_nx = g_d;
        end
      end else begin
        mask_nx = mask | onehot_c;
      end
      if (grp_end_d)
        mask_nx = '0;
`ifdef EARLY_EXIT_EN
      if (bad_c)
        state_nx = ST_REPORT;
`endif
    end

    if (state_nx == ST_REPORT)
      solved_nx = !err_nx;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state         <= ST_IDLE;
      g             <= '0;
      i             <= '0;
      g_d           <= '0;
      grp_end_d     <= 1'b0;
      vld_d         <= 1'b0;
      mask          <= '0;
      err           <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.solved    <= 1'b0;
      bus.err_group <= ERR_NONE;
    end else begin
      state         <= state_nx;
      g             <= g_nx;
      i             <= i_nx;
      g_d           <= g;
      grp_end_d     <= (i == IDX_W'(GRID-1));
      vld_d         <= bus.rd_en;
      mask          <= mask_nx;
      err           <= err_nx;
      bus.rd_en     <= (state_nx == ST_SCAN);
      bus.rd_addr   <= (state_nx == ST_SCAN) ? addr_c : '0;
      bus.busy      <= (state_nx != ST_IDLE);
      bus.done      <= (state_nx == ST_REPORT);
      bus.solved    <= solved_nx;
      bus.err_group <= err_group_nx;
    end
  end

endmodule
